// File: rtl/riscv_pkg.sv
// Shared datapath types and constants for the single-cycle RISC core.
package riscv_pkg;

  localparam int REG_W    = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: NREGS:1 word select with R0 and write-bypass overrides.
module regfile_read_port
  import riscv_pkg::*;
#(
  parameter int DATA_W   = REG_W,
  parameter int ADDR_W   = REG_AW,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b0
) (
  input  logic [DATA_W-1:0] i_mem [2**ADDR_W],
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic w_isZero;
  logic w_bypassHit;

  assign w_isZero    = ZERO_REG && (i_raddr == ADDR_W'(REG_ZERO));
  assign w_bypassHit = BYPASS && i_we && (i_raddr == i_waddr);

  // R0 wins over bypass so a dropped write to R0 never shows up on a read.
  always_comb begin
    o_rdata = i_mem[i_raddr];
    if (w_isZero) begin
      o_rdata = '0;
    end else if (w_bypassHit) begin
      o_rdata = i_wdata;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// 2-read / 1-write general-purpose register file with optional hardwired-zero R0.
module reg_file_2r1w
  import riscv_pkg::*;
#(
  parameter int DATA_W   = REG_W,
  parameter int ADDR_W   = REG_AW,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [NREGS];
  logic [NREGS-1:0]  w_wrEn;
  logic              w_bypassWe;

  always_comb begin
    w_wrEn = '0;
    if (we) begin
      w_wrEn[waddr] = 1'b1;
    end
    if (ZERO_REG) begin
      w_wrEn[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wrEn[i]) begin
          r_mem[i] <= wdata;
        end
      end
    end
  end

  // Reset must force zero reads even when a bypassed write is pending.
  assign w_bypassWe = we && rst_n;

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_readPort1 (
    .i_mem  (r_mem),
    .i_raddr(raddr1),
    .i_we   (w_bypassWe),
    .i_waddr(waddr),
    .i_wdata(wdata),
    .o_rdata(rdata1)
  );

  regfile_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_readPort2 (
    .i_mem  (r_mem),
    .i_raddr(raddr2),
    .i_we   (w_bypassWe),
    .i_waddr(waddr),
    .i_wdata(wdata),
    .o_rdata(rdata2)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: stimulus pushes expected reads, a negedge monitor compares.
module tb_reg_file_2r1w;
  import riscv_pkg::*;

  localparam bit BYPASS   = 1'b0;
  localparam bit ZERO_REG = 1'b1;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      we;
  reg_addr_t waddr;
  word_t     wdata;
  reg_addr_t raddr1;
  word_t     rdata1;
  reg_addr_t raddr2;
  word_t     rdata2;

  always #5 clk = ~clk;

  reg_file_2r1w #(
    .DATA_W  (REG_W),
    .ADDR_W  (REG_AW),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr1(raddr1),
    .rdata1(rdata1),
    .raddr2(raddr2),
    .rdata2(rdata2)
  );

  typedef struct {
    word_t exp1;
    word_t exp2;
    string tag;
  } scoreEntry_t;

  scoreEntry_t sbQueue[$];
  word_t       refRegs [NUM_REGS];
  int          checkCount = 0;
  int          errorCount = 0;

  function automatic void clearModel();
    for (int i = 0; i < NUM_REGS; i++) refRegs[i] = 32'h0;
  endfunction

  // What a register-file read must return given the current inputs.
  function automatic word_t refRead(reg_addr_t a);
    if (!rst_n) return 32'h0;
    if (ZERO_REG && a == 5'd0) return 32'h0;
    if (BYPASS && we && a == waddr) return wdata;
    return refRegs[a];
  endfunction

  // Called just after a rising edge, while last cycle's inputs are still driven.
  function automatic void commitWrite();
    if (rst_n && we && !(ZERO_REG && waddr == 5'd0)) refRegs[waddr] = wdata;
  endfunction

  task automatic checkOutput(input word_t actual, input word_t required, input string name);
    checkCount++;
    if (actual !== required) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%08h required=%08h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input bit iWe, input reg_addr_t iWaddr, input word_t iWdata,
                               input reg_addr_t iR1, input reg_addr_t iR2, input string tag);
    scoreEntry_t e;
    @(posedge clk);
    commitWrite();
    #1;
    we     = iWe;
    waddr  = iWaddr;
    wdata  = iWdata;
    raddr1 = iR1;
    raddr2 = iR2;
    e.exp1 = refRead(iR1);
    e.exp2 = refRead(iR2);
    e.tag  = tag;
    sbQueue.push_back(e);
  endtask

  task automatic asyncResetCheck(input reg_addr_t ra);
    scoreEntry_t e;
    @(posedge clk);
    commitWrite();
    #1;
    we     = 1'b0;
    raddr1 = ra;
    raddr2 = ra;
    rst_n  = 1'b0;
    clearModel();
    e.exp1 = refRead(ra);
    e.exp2 = refRead(ra);
    e.tag  = "asyncReset";
    sbQueue.push_back(e);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic resetAcrossEdge();
    scoreEntry_t e;
    @(posedge clk);
    commitWrite();
    #1;
    rst_n = 1'b0;
    clearModel();
    we    = 1'b1;
    waddr = 5'd12;
    wdata = 32'h5555_5555;
    @(posedge clk);
    commitWrite();
    #1;
    rst_n  = 1'b1;
    we     = 1'b0;
    raddr1 = 5'd12;
    raddr2 = 5'd12;
    e.exp1 = refRead(5'd12);
    e.exp2 = refRead(5'd12);
    e.tag  = "resetPriority";
    sbQueue.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    scoreEntry_t e;
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkOutput(rdata1, e.exp1, {e.tag, "/rd1"});
      checkOutput(rdata2, e.exp2, {e.tag, "/rd2"});
    end
  end

  initial begin
    scoreEntry_t e;
    reg_addr_t   ra;
    rst_n  = 1'b0;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr1 = 5'd5;
    raddr2 = 5'd31;
    clearModel();
    #1;
    e.exp1 = refRead(5'd5);
    e.exp2 = refRead(5'd31);
    e.tag  = "resetState";
    sbQueue.push_back(e);
    @(negedge clk);
    #2 rst_n = 1'b1;

    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, "writeR5");
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "readR5");
    asyncResetCheck(5'd5);

    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 5'd3, 32'hCAFE_BABE, 5'd3, 5'd3, "weLowHold");

    for (int k = 1; k < 32; k++)
      applyStimulus(1'b1, reg_addr_t'(k), 32'h1000_0000 + k, reg_addr_t'(k), reg_addr_t'(31 - k), "fillAll");
    for (int k = 0; k < 32; k++)
      applyStimulus(1'b0, 5'd0, 32'h0, reg_addr_t'(k), reg_addr_t'(31 - k), "sweepAll");

    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "r0Write");
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "r0Read");

    applyStimulus(1'b1, 5'd7, 32'h1111_1111, 5'd1, 5'd1, "rdwSetup");
    applyStimulus(1'b1, 5'd7, 32'h2222_2222, 5'd0, 5'd7, "rdwBefore");
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, "rdwAfter");

    applyStimulus(1'b1, 5'd9, 32'h0000_ABCD, 5'd9, 5'd9, "dualSetup");
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, "dualSame");

    resetAcrossEdge();

    // Bias read addresses toward the write address to exercise read-during-write.
    for (int i = 0; i < 300; i++) begin
      ra = reg_addr_t'($urandom);
      applyStimulus(1'($urandom), ra, word_t'($urandom),
                    ($urandom_range(0, 1) == 0) ? ra : reg_addr_t'($urandom),
                    ($urandom_range(0, 3) == 0) ? ra : reg_addr_t'($urandom),
                    "random");
    end

    for (int i = 0; i < 10 && sbQueue.size() > 0; i++) @(negedge clk);
    #1;
    if (sbQueue.size() > 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL drain actual=%0d entries required=0 entries", sbQueue.size());
    end
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
